// File: rtl/gf180mcu_clk_en_sequencer_if.sv
// Request/enable bundle for the staggered clock-enable sequencer.
// The master drives REQ/GAP; the slave (the sequencer) returns EN/ACK/BUSY.
interface gf180mcu_clk_en_sequencer_if #(
  parameter int N_DOM = 4,
  parameter int GAP_W = 4
);
  logic [N_DOM-1:0] req;
  logic [GAP_W-1:0] gap;
  logic [N_DOM-1:0] en;
  logic [N_DOM-1:0] ack;
  logic             busy;

  modport master (output req, gap, input en, ack, busy);
  modport slave  (input req, gap, output en, ack, busy);
endinterface

// File: rtl/gf180mcu_clk_en_sequencer.sv
// Round-robin clock-enable sequencer: toggles one domain enable at a time and
// waits a programmable settle gap. Define CLKSEQ_FAST_OFF_EN to skip the gap on turn-off.
module gf180mcu_clk_en_sequencer #(
  parameter int N_DOM = 4,
  parameter int GAP_W = 4
) (
  input logic                       clk_i,
  input logic                       rn_i,
  gf180mcu_clk_en_sequencer_if.slave bus
);

  localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [PTR_W:0]   N_DOM_L  = (PTR_W+1)'(N_DOM);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_DOM - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [N_DOM-1:0]   en_q, en_d;
  logic [N_DOM-1:0]   ack_q, ack_d;

  logic [N_DOM-1:0]   pend;
  logic [PTR_W:0]     cand;
  logic [PTR_W-1:0]   pick;
  logic               found;

  // Round-robin search: walking downward means the lowest offset from ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pend  = bus.req ^ en_q;
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int j = N_DOM - 1; j >= 0; j--) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(j);
      if (cand >= N_DOM_L) cand = cand - N_DOM_L;
      if (pend[cand[PTR_W-1:0]]) begin
        pick  = cand[PTR_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    en_d    = en_q;
    ack_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          en_d[pick] = ~en_q[pick];
`ifdef CLKSEQ_FAST_OFF_EN
          cnt_d      = en_q[pick] ? '0 : bus.gap;
`else
          cnt_d      = bus.gap;
`endif
          sel_d      = pick;
          ptr_d      = (pick == LAST_IDX) ? '0 : pick + PTR_W'(1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - GAP_W'(1);
        end else begin
          ack_d[sel_q] = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset mid-window drops every enable on the same edge and forgets the window.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      en_q    <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.en   = en_q;
  assign bus.ack  = ack_q;
  assign bus.busy = (state_q == S_WAIT);

endmodule

// File: tb/tb_gf180mcu_clk_en_sequencer.sv
// Bench for gf180mcu_clk_en_sequencer: an edge-indexed reference model predicts
// EN/BUSY each cycle and queues expected ACK pulses that a monitor pops.
module tb_gf180mcu_clk_en_sequencer;
  localparam int N  = 4;
  localparam int GW = 4;

  typedef struct {
    int dom;
    int edge_at;
  } ack_t;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  gf180mcu_clk_en_sequencer_if #(.N_DOM(N), .GAP_W(GW)) bus ();

  gf180mcu_clk_en_sequencer #(.N_DOM(N), .GAP_W(GW)) dut (
    .clk_i (clk),
    .rn_i  (rn),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at edge", name, act, exp);
    end
  endtask

  // Reference model: toggles are scheduled by edge number from the timing rules.
  ack_t         exp_q[$];
  int           edge_n   = 0;
  int           next_ok  = 0;
  int           rr_ptr   = 0;
  logic [N-1:0] m_en     = '0;
  logic         exp_busy = 1'b0;
  logic         rst_edge = 1'b1;

  always @(posedge clk) begin
    logic [N-1:0] pend;
    int           dom;
    int           g;
    edge_n++;
    rst_edge = !rn;
    if (!rn) begin
      m_en    = '0;
      rr_ptr  = 0;
      next_ok = edge_n + 1;
      exp_q.delete();
    end else begin
      pend = bus.req ^ m_en;
      if (edge_n >= next_ok && pend != '0) begin
        dom = -1;
        for (int j = 0; j < N; j++) begin
          if (dom < 0 && pend[(rr_ptr + j) % N]) dom = (rr_ptr + j) % N;
        end
        g = int'(bus.gap);
`ifdef CLKSEQ_FAST_OFF_EN
        if (m_en[dom]) g = 0;
`endif
        m_en[dom] = ~m_en[dom];
        rr_ptr    = (dom + 1) % N;
        next_ok   = edge_n + g + 2;
        exp_q.push_back('{dom: dom, edge_at: edge_n + g + 1});
      end
    end
    exp_busy = (edge_n < next_ok - 1);
  end

  // Monitor: compares outputs half a cycle after each edge.
  logic [N-1:0] prev_en = '0;
  always @(negedge clk) begin
    logic [N-1:0] exp_ack;
    if (edge_n > 0) begin
      exp_ack = '0;
      if (exp_q.size() > 0 && exp_q[0].edge_at == edge_n) begin
        exp_ack = N'(1) << exp_q[0].dom;
        void'(exp_q.pop_front());
      end
      check("ack", 32'(bus.ack), 32'(exp_ack));
      check("en", 32'(bus.en), 32'(m_en));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      if (!rst_edge) check("one_en_change", 32'($countones(bus.en ^ prev_en) <= 1), 32'd1);
      prev_en = bus.en;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rn      = 1'b0;
    bus.req = '0;
    tick(2);
    rn = 1'b1;
  endtask

  initial begin
    bus.req = '0;
    bus.gap = '0;
    @(negedge clk);
    // Requests held through reset must not act until reset releases.
    bus.req = 4'hF;
    bus.gap = 4'd5;
    tick(2);
    rn = 1'b1;
    tick(30);

    do_reset();
    bus.gap = 4'd3;
    tick(1);
    bus.req = 4'b0001;
    tick(8);

    do_reset();
    bus.gap = 4'd2;
    bus.req = 4'hF;
    tick(20);

    do_reset();
    bus.gap = 4'd1;
    bus.req = 4'b0100;
    tick(5);
    bus.req = 4'b1101;
    tick(10);

    do_reset();
    bus.gap = 4'd6;
    bus.req = 4'b0010;
    tick(3);
    bus.req = 4'b0000;
    tick(20);

    do_reset();
    bus.gap = 4'd1;
    bus.req = 4'b0111;
    tick(10);
    bus.gap = 4'd6;
    bus.req = 4'hF;
    tick(3);
    rn = 1'b0;
    tick(1);
    rn = 1'b1;
    bus.req = '0;
    bus.gap = 4'd7;
    tick(2);
    bus.req = 4'b0001;
    tick(12);
    bus.req = 4'b0000;
    tick(12);

    // Randomized traffic, including GAP changes mid-window and rare resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.req = N'($urandom);
      bus.gap = GW'($urandom_range(0, 4));
      rn = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rn = 1'b1;
    tick(120);
    check("ack_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
